// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the stopwatch button front-end.
package button_conditioner_pkg;

  // Button bit positions within buttonRaw / buttonLevel.
  localparam int BTN_MODE  = 0;
  localparam int BTN_START = 1;
  localparam int BTN_SPLIT = 2;
  localparam int NUM_BTN   = 3;

  // Split/reset press classifier states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } split_state_e;

  // Milliseconds to clock cycles; divide first so large clocks stay in range.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Period of a rate in Hz, in clock cycles.
  function automatic int hz_to_cycles(input int clk_hz, input int hz);
    return clk_hz / hz;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: two-flop synchroniser, stability-count debouncer and a
// registered rising-edge pulse of the debounced level.
module button_debouncer #(
  parameter int DEB_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise_pulse
);

  localparam int               CNT_W    = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: count consecutive mismatches; the level follows the
  // synchronised input only once the mismatch has lasted DEB_CYC edges.
  always_comb begin
    sync_d      = {sync_q[0], raw_in};
    level_d     = level_q;
    cnt_d       = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    level_dly_d = level_q;
    pulse_d     = level_q & ~level_dly_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch front-end: debounced buttons, command pulses, short/long
// split-reset classification and the 100 Hz time-base enable.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1500
) (
  input  logic               clockSignal,
  input  logic               resetN,
  input  logic [NUM_BTN-1:0] buttonRaw,
  output logic [NUM_BTN-1:0] buttonLevel,
  output logic               modePulse,
  output logic               startStopPulse,
  output logic               splitPulse,
  output logic               resetPulse,
  output logic               tick100Hz
);

  localparam int DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
  localparam int TICK_CYC = hz_to_cycles(CLK_HZ, 100);

  localparam int                HOLD_W    = $clog2(LONG_CYC + 1);
  localparam int                TICK_W    = $clog2(TICK_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

  logic [NUM_BTN-1:0] rise;
  logic               unused_split_rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEB_CYC(DEB_CYC)
    ) u_deb (
      .clk       (clockSignal),
      .rst_n     (resetN),
      .raw_in    (buttonRaw[i]),
      .level     (buttonLevel[i]),
      .rise_pulse(rise[i])
    );
  end

  assign modePulse         = rise[BTN_MODE];
  assign startStopPulse    = rise[BTN_START];
  // Split/reset is classified by the FSM below, not by its rise pulse.
  assign unused_split_rise = rise[BTN_SPLIT];

  // ---------------------------------------------------------------------
  // Split/reset classifier. The FSM sees the registered debounced level,
  // so PRESSED starts one edge after buttonLevel[2] rises and resetPulse
  // appears LONG_CYC+1 edges after that rise. A release seen on the same
  // cycle as the threshold is checked first, so it becomes a split.
  // ---------------------------------------------------------------------
  split_state_e      state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              split_q, split_d;
  logic              reset_q, reset_d;
  logic              split_level;

  assign split_level = buttonLevel[BTN_SPLIT];

  // Next-state and registered pulse requests for the split/reset press.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    split_d = 1'b0;
    reset_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (split_level) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!split_level) begin
          split_d = 1'b1;
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          reset_d = 1'b1;
          state_d = LONG_HELD;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!split_level) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Split/reset FSM registers.
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      hold_q  <= '0;
      split_q <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      split_q <= split_d;
      reset_q <= reset_d;
    end
  end

  assign splitPulse = split_q;
  assign resetPulse = reset_q;

  // ---------------------------------------------------------------------
  // 100 Hz time base: free-running 0..TICK_CYC-1 counter, enable asserted
  // while it sits at its last value.
  // ---------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

  // Tick counter next value with wrap.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end
  end

  // Tick counter register.
  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick100Hz = (tick_cnt_q == TICK_LAST);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEB_CYC=100, LONG_CYC=1000,
// TICK_CYC=1000. Edge index 0 is the first rising edge after the stimulus
// change; an output observed 1 ns after edge e is "high after edge e".
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic [2:0] buttonRaw;
  logic [2:0] buttonLevel;
  logic       modePulse, startStopPulse, splitPulse, resetPulse, tick100Hz;

  int checks = 0;
  int errors = 0;

  // Per-scenario observations.
  int edge_n;
  int mode_cnt, mode_first, ss_cnt, ss_first;
  int split_cnt, split_first, reset_cnt, reset_first;
  int tick_cnt, tick_first, tick_last, tick_adj;
  int lvl_rise[3];
  int lvl_fall[3];
  logic [2:0] lvl_prev;
  logic       tick_prev;

  button_conditioner #(
    .CLK_HZ       (100_000),
    .DEBOUNCE_MS  (1),
    .LONG_PRESS_MS(10)
  ) dut (
    .clockSignal   (clk),
    .resetN        (resetN),
    .buttonRaw     (buttonRaw),
    .buttonLevel   (buttonLevel),
    .modePulse     (modePulse),
    .startStopPulse(startStopPulse),
    .splitPulse    (splitPulse),
    .resetPulse    (resetPulse),
    .tick100Hz     (tick100Hz)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    edge_n      = -1;
    mode_cnt    = 0; mode_first  = -1;
    ss_cnt      = 0; ss_first    = -1;
    split_cnt   = 0; split_first = -1;
    reset_cnt   = 0; reset_first = -1;
    tick_cnt    = 0; tick_first  = -1; tick_last = -1; tick_adj = 0;
    for (int b = 0; b < 3; b++) begin
      lvl_rise[b] = -1;
      lvl_fall[b] = -1;
    end
    lvl_prev  = buttonLevel;
    tick_prev = tick100Hz;
  endtask

  // Advance n rising edges, sampling 1 ns after each.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (modePulse) begin
        if (mode_cnt == 0) mode_first = edge_n;
        mode_cnt++;
      end
      if (startStopPulse) begin
        if (ss_cnt == 0) ss_first = edge_n;
        ss_cnt++;
      end
      if (splitPulse) begin
        if (split_cnt == 0) split_first = edge_n;
        split_cnt++;
      end
      if (resetPulse) begin
        if (reset_cnt == 0) reset_first = edge_n;
        reset_cnt++;
      end
      for (int b = 0; b < 3; b++) begin
        if (buttonLevel[b] && !lvl_prev[b] && lvl_rise[b] < 0) lvl_rise[b] = edge_n;
        if (!buttonLevel[b] && lvl_prev[b] && lvl_fall[b] < 0) lvl_fall[b] = edge_n;
      end
      lvl_prev = buttonLevel;
      if (tick100Hz) begin
        if (tick_cnt == 0) tick_first = edge_n;
        tick_last = edge_n;
        if (tick_prev) tick_adj++;
        tick_cnt++;
      end
      tick_prev = tick100Hz;
    end
  endtask

  // Reset with buttons released; returns 1 ns after a rising edge.
  task automatic apply_reset();
    resetN    = 1'b0;
    buttonRaw = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    clear_stats();
  endtask

  initial begin
    resetN    = 1'b0;
    buttonRaw = 3'b000;
    #1;
    check("rst_level", int'(buttonLevel), 0);
    check("rst_pulses", int'({modePulse, startStopPulse, splitPulse, resetPulse}), 0);
    check("rst_tick", int'(tick100Hz), 0);

    // 1: clean mode press held 500 cycles.
    apply_reset();
    buttonRaw = 3'b001;
    run_cycles(500);
    buttonRaw = 3'b000;   // release sampled at edge 500
    run_cycles(300);
    check("s1_mode_cnt", mode_cnt, 1);
    check("s1_mode_edge", mode_first, 102);
    check("s1_lvl_rise", lvl_rise[0], 101);
    check("s1_lvl_fall", lvl_fall[0], 601);
    check("s1_ss_cnt", ss_cnt, 0);

    // 2: start/stop bounces every 30 cycles, final rise at edge 300.
    apply_reset();
    for (int s = 0; s < 10; s++) begin
      buttonRaw[1] = (s % 2 == 0);
      run_cycles(30);
    end
    buttonRaw[1] = 1'b1;
    run_cycles(300);
    buttonRaw = 3'b000;
    check("s2_ss_cnt", ss_cnt, 1);
    check("s2_ss_edge", ss_first, 402);
    check("s2_mode_cnt", mode_cnt, 0);

    // 3: short split press held 400 cycles.
    apply_reset();
    buttonRaw = 3'b100;
    run_cycles(400);
    buttonRaw = 3'b000;   // release at edge 400
    run_cycles(300);
    check("s3_split_cnt", split_cnt, 1);
    check("s3_split_edge", split_first, 502);
    check("s3_reset_cnt", reset_cnt, 0);

    // 4: long split press held 3000 cycles; level rises at 101, the FSM
    // enters PRESSED at 102 and counts 1000 cycles there.
    apply_reset();
    buttonRaw = 3'b100;
    run_cycles(3000);
    buttonRaw = 3'b000;
    run_cycles(300);
    check("s4_lvl_rise", lvl_rise[2], 101);
    check("s4_reset_cnt", reset_cnt, 1);
    check("s4_reset_edge", reset_first, 1102);
    check("s4_split_cnt", split_cnt, 0);
    check("s4_state_idle", int'(dut.state_q), int'(IDLE));

    // 5: idle for 5000 cycles; tick high after edge index 998 (the 999th
    // edge) so it is consumed on the 1000th edge, then every 1000.
    apply_reset();
    run_cycles(5000);
    check("s5_tick_cnt", tick_cnt, 5);
    check("s5_tick_first", tick_first, 998);
    check("s5_tick_last", tick_last, 4998);
    check("s5_tick_width", tick_adj, 0);
    check("s5_no_pulses", mode_cnt + ss_cnt + split_cnt + reset_cnt, 0);

    // 6: mode held, reset asserted at cycle 300 while still held.
    apply_reset();
    buttonRaw = 3'b001;
    run_cycles(300);
    check("s6_first_pulse", mode_cnt, 1);
    resetN = 1'b0;
    #1;
    check("s6_rst_level", int'(buttonLevel), 0);
    check("s6_rst_pulses", int'({modePulse, startStopPulse, splitPulse, resetPulse, tick100Hz}), 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    clear_stats();
    run_cycles(300);
    check("s6_mode_cnt", mode_cnt, 1);
    check("s6_mode_edge", mode_first, 102);
    check("s6_lvl_rise", lvl_rise[0], 101);
    buttonRaw = 3'b000;

    // 7: simultaneous mode and start/stop presses.
    apply_reset();
    buttonRaw = 3'b011;
    run_cycles(200);
    buttonRaw = 3'b000;
    run_cycles(150);
    check("s7_mode_edge", mode_first, 102);
    check("s7_ss_edge", ss_first, 102);
    check("s7_both_cnt", mode_cnt + ss_cnt, 2);

    // 8: 99-cycle glitch is filtered; a 100-cycle press is accepted.
    apply_reset();
    buttonRaw = 3'b001;
    run_cycles(99);
    buttonRaw = 3'b000;
    run_cycles(300);
    check("s8_short_cnt", mode_cnt, 0);
    check("s8_short_lvl", lvl_rise[0], -1);
    apply_reset();
    buttonRaw = 3'b001;
    run_cycles(100);
    buttonRaw = 3'b000;
    run_cycles(300);
    check("s8_exact_cnt", mode_cnt, 1);
    check("s8_exact_edge", mode_first, 102);
    check("s8_exact_fall", lvl_fall[0], 201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that drives the stopwatch/timer core's control inputs and time base.
- Synchronises and debounces three raw push-buttons: mode, start/stop, split/reset.
- Emits single-cycle command pulses; split/reset is split into a short-press split and a long-press reset.
- Generates the 100 Hz time-base enable the core counts on.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
DEBOUNCE_MS, 20, input must be stable this long before the debounced level changes
LONG_PRESS_MS, 1500, hold time on split/reset that turns it into a reset
Derived: DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS; LONG_CYC = CLK_HZ/1000*LONG_PRESS_MS; TICK_CYC = CLK_HZ/100

Ports:
clockSignal  in  1  system clock, all state on rising edge
resetN  in  1  asynchronous, active-low reset
buttonRaw  in  3  raw active-high buttons: [0] mode, [1] startOrStop, [2] splitOrReset
buttonLevel  out  3  debounced levels, same bit order
modePulse  out  1  one-cycle pulse on debounced mode press
startStopPulse  out  1  one-cycle pulse on debounced start/stop press
splitPulse  out  1  one-cycle pulse on short split/reset press, issued at release
resetPulse  out  1  one-cycle pulse when split/reset has been held LONG_CYC cycles
tick100Hz  out  1  one-cycle enable every TICK_CYC cycles

Behaviour:
- Reset (resetN low, async): all outputs 0; sync flops, debounce counters, hold counter and tick counter 0; FSM IDLE.
- Sync: two flops per bit. Raw sampled high at edge 0 appears at the sync output after edge 1.
- Debounce, per bit:
  - Counter clears whenever sync == debounced level; otherwise it increments.
  - On the edge where the mismatch count reaches DEB_CYC, the level takes the sync value and the counter clears.
  - Pulses shorter than DEB_CYC cycles are never seen.
- Press pulses: modePulse/startStopPulse are registered rising-edge detects of the debounced level.
  - Latency: pulse is high for exactly the cycle after edge DEB_CYC+2, counted from the first edge that samples raw high.
  - No pulse on release. Holding the button gives exactly one pulse (no auto-repeat).
- Split/reset FSM, on debounced bit 2:
  - IDLE: on level rise -> PRESSED, holdCnt = 0.
  - PRESSED, level low: splitPulse for 1 cycle -> IDLE.
  - PRESSED, level high, holdCnt == LONG_CYC-1: resetPulse for 1 cycle -> LONG_HELD.
  - PRESSED, otherwise: holdCnt + 1.
  - LONG_HELD: on level low -> IDLE, no pulse.
  - Release and threshold on the same cycle: release wins (split).
  - splitPulse and resetPulse never assert for the same press.
- Buttons are independent: simultaneous presses give simultaneous pulses on their respective outputs, with no priority.
- Tick:
  - Counter runs 0..TICK_CYC-1 and wraps.
  - tick100Hz is high in the cycle the counter equals TICK_CYC-1.
  - The first tick after reset release occurs after TICK_CYC edges.
  - The tick runs regardless of buttons.
- Reset mid-press: all state clears. A button still held after resetN deasserts is treated as a new press: full debounce, then a pulse; the long-press count restarts from 0.
- Widths: every counter is $clog2(max+1) bits; counters saturate logically via the state transitions and never wrap unintentionally.

Decomposition:
- Package button_conditioner_pkg holds:
  - The split/reset FSM state enum (IDLE, PRESSED, LONG_HELD).
  - Derived-cycle constant functions (ms to cycles).
  - The button index constants BTN_MODE=0, BTN_START=1, BTN_SPLIT=2.
- Sub-module button_debouncer (sync + debounce + registered rise pulse, parameterised by DEB_CYC), instantiated 3x.
- FSM and tick generator stay in the top module.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=100_000, DEBOUNCE_MS=1, LONG_PRESS_MS=10, giving DEB_CYC=100, LONG_CYC=1000, TICK_CYC=1000.
1. Clean mode press held 500 cycles -> modePulse high for exactly one cycle, at edge 102 after the first sample; buttonLevel[0] high from edge 101 to release+101; no second pulse.
2. Bounce: startOrStop toggles every 30 cycles for 300 cycles, then stays high -> no pulse during the bounce; exactly one startStopPulse 102 edges after the final rising transition.
3. splitOrReset held 400 cycles -> single splitPulse at release+102; resetPulse never asserts.
4. splitOrReset held 3000 cycles -> resetPulse once, 1000 cycles after buttonLevel[2] rises; no splitPulse on release; FSM back to IDLE.
5. No buttons for 5000 cycles after reset -> tick100Hz pulses at edges 1000, 2000, ... 5000; each pulse exactly one cycle wide.
6. Mode held, resetN pulsed low mid-hold at cycle 300, button kept high -> all outputs 0 immediately; a new modePulse 102 edges after resetN release.
